// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and helpers for the hazard scoreboard
// Purpose: forward-select encodings, default widths and the forward-priority
// helper used by hazard_scoreboard.
// Ports: none (package).
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int DEF_REG_AW = 4;
  localparam int DEF_NUM_MC = 2;

  // The M stage holds the younger result, so it beats W. The PC register
  // always comes from the register file.
  function automatic logic [1:0] fwd_select(input logic is_pc,
                                            input logic m_hit,
                                            input logic w_hit);
    if (is_pc)      return FWD_RF;
    else if (m_hit) return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/mc_tracker.sv
// rtl/mc_tracker.sv - busy flag and destination tag for one multi-cycle unit
// Purpose: records that a unit is occupied and which register it will write.
// Ports:
//   CLK, RESETn   clock, asynchronous active-low reset
//   issue         an operation issues to this unit at the next edge
//   issue_tag     destination register of the issuing operation
//   done          completion pulse from the unit
//   busy, tag     registered occupancy and destination tag
module mc_tracker #(
  parameter int REG_AW = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_tag,
  input  logic              done,
  output logic              busy,
  output logic [REG_AW-1:0] tag
);

  // Issue has priority so a back-to-back done/issue leaves the unit busy
  // with the new tag.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      busy <= 1'b0;
      tag  <= '0;
    end else if (issue) begin
      busy <= 1'b1;
      tag  <= issue_tag;
    end else if (done) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard unit with multi-cycle scoreboard
// Purpose: operand forwarding, load-use / scoreboard / structural stalls,
// branch flushes and memory-freeze control for a 5-stage pipeline with
// NUM_MC multi-cycle units.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating counters.
// Ports:
//   CLK, RESETn                      clock, asynchronous active-low reset
//   RA1D, RA2D, WA3D, RegWriteD      decode sources/destination/write flag
//   MCSelD                           one-hot multi-cycle unit select in decode
//   RA1E, RA2E, WA3E                 execute sources/destination
//   RegWriteE, MemtoRegE             execute write and load flags
//   WA3M, RegWriteM, WA3W, RegWriteW later-stage writes
//   MCDone                           per-unit completion pulse
//   PCSrcE                           taken branch in execute
//   MemStall                         cache miss freeze
//   ForwardAE, ForwardBE             forward selects (M / W / register file)
//   StallF..StallW, FlushD, FlushE   pipeline controls
//   SBBusy                           pending-write vector
//   MCErr                            sticky done-without-issue error
//   StallCnt, FlushCnt, MemStallCnt  performance counters (optional)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int NUM_MC = DEF_NUM_MC
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic [REG_AW-1:0]        RA1D,
  input  logic [REG_AW-1:0]        RA2D,
  input  logic [REG_AW-1:0]        WA3D,
  input  logic                     RegWriteD,
  input  logic [NUM_MC-1:0]        MCSelD,
  input  logic [REG_AW-1:0]        RA1E,
  input  logic [REG_AW-1:0]        RA2E,
  input  logic [REG_AW-1:0]        WA3E,
  input  logic                     RegWriteE,
  input  logic                     MemtoRegE,
  input  logic [REG_AW-1:0]        WA3M,
  input  logic [REG_AW-1:0]        WA3W,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic [NUM_MC-1:0]        MCDone,
  input  logic                     PCSrcE,
  input  logic                     MemStall,
  output logic [1:0]               ForwardAE,
  output logic [1:0]               ForwardBE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     StallW,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic [(1<<REG_AW)-1:0]   SBBusy,
  output logic                     MCErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]              StallCnt,
  output logic [31:0]              FlushCnt,
  output logic [31:0]              MemStallCnt
`endif
);

  localparam int               NREG = 1 << REG_AW;
  localparam logic [REG_AW-1:0] PC  = {REG_AW{1'b1}};

  // ---------------- forwarding ----------------
  assign ForwardAE = fwd_select(RA1E == PC,
                                RegWriteM && (WA3M == RA1E),
                                RegWriteW && (WA3W == RA1E));
  assign ForwardBE = fwd_select(RA2E == PC,
                                RegWriteM && (WA3M == RA2E),
                                RegWriteW && (WA3W == RA2E));

  // ---------------- multi-cycle units ----------------
  logic [NUM_MC-1:0] mc_busy;
  logic [REG_AW-1:0] mc_tag [NUM_MC];
  logic              issue_en;
  logic [NUM_MC-1:0] done_ok;

  assign done_ok = MCDone & mc_busy;

  for (genvar i = 0; i < NUM_MC; i++) begin : g_mc
    mc_tracker #(.REG_AW(REG_AW)) u_trk (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .issue     (issue_en & MCSelD[i]),
      .issue_tag (WA3D),
      .done      (MCDone[i]),
      .busy      (mc_busy[i]),
      .tag       (mc_tag[i])
    );
  end

  // ---------------- stall / flush ----------------
  logic sb_stall;
  logic ldr_stall;
  logic hazard;

  // Only registered scoreboard state is consulted, so a done pulse releases
  // the stall one cycle after its edge.
  assign sb_stall  = SBBusy[RA1D] | SBBusy[RA2D] | SBBusy[WA3D] | (|(MCSelD & mc_busy));
  assign ldr_stall = MemtoRegE & RegWriteE & (WA3E != PC) &
                     ((WA3E == RA1D) | (WA3E == RA2D));
  assign hazard    = sb_stall | ldr_stall;

  // A taken branch squashes decode, so its hazards are irrelevant.
  assign StallF = MemStall | (~PCSrcE & hazard);
  assign StallD = StallF;
  assign StallE = MemStall;
  assign StallM = MemStall;
  assign StallW = MemStall;
  assign FlushD = ~MemStall & PCSrcE;
  assign FlushE = ~MemStall & (PCSrcE | hazard);

  assign issue_en = ~StallD & ~FlushD;

  // ---------------- scoreboard ----------------
  logic [NREG-1:0] sb_next;

  // Clears are applied before the set so a same-edge issue and done of one
  // register leaves it pending.
  always_comb begin
    sb_next = SBBusy;
    for (int i = 0; i < NUM_MC; i++) begin
      if (done_ok[i]) sb_next[mc_tag[i]] = 1'b0;
    end
    if (issue_en && (|MCSelD) && RegWriteD && (WA3D != PC)) sb_next[WA3D] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      SBBusy <= '0;
      MCErr  <= 1'b0;
    end else begin
      SBBusy <= sb_next;
      MCErr  <= MCErr | (|(MCDone & ~mc_busy));
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      StallCnt    <= '0;
      FlushCnt    <= '0;
      MemStallCnt <= '0;
    end else begin
      if (StallD && (StallCnt != '1))      StallCnt    <= StallCnt + 32'd1;
      if (FlushE && (FlushCnt != '1))      FlushCnt    <= FlushCnt + 32'd1;
      if (MemStall && (MemStallCnt != '1)) MemStallCnt <= MemStallCnt + 32'd1;
    end
  end
`endif

endmodule
